process_scheduler: RTL and testbench

//  Round-robin, time-sliced scheduler for the core's process slots. Tracks a ready mask, counts quantum,

---
 rtl/process_scheduler.sv | 176 +++++++++++++++++
 tb/tb_process_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/process_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : process_scheduler
// Description : Round-robin, time-sliced process scheduler with a context
//               switch handshake. Optional macro SCHED_STATS_EN adds a
//               switch_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module process_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PROCS  = 8,
    parameter int QUANTUM    = 16,
    localparam int PW        = $clog2(NUM_PROCS + 1),
    localparam int CW        = $clog2(QUANTUM)
) (
    input  logic                  single_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  set_valid,
    input  logic [PW-1:0]         set_pid,
    input  logic                  clr_valid,
    input  logic [PW-1:0]         clr_pid,
    input  logic                  yield,
    output logic                  switch_req,
    input  logic                  switch_ack,
    output logic [DATA_WIDTH-1:0] next_proc,
    output logic [DATA_WIDTH-1:0] cur_proc,
    output logic [DATA_WIDTH-1:0] new_proc_num,
    output logic                  idle
`ifdef SCHED_STATS_EN
    ,
    output logic [DATA_WIDTH-1:0] switch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REQ    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_RELOAD = CW'(QUANTUM - 1);

    state_t                 state_q;
    logic [NUM_PROCS-1:0]   mask_q;
    logic [NUM_PROCS-1:0]   mask_d;
    logic [PW-1:0]          cur_q;
    logic [PW-1:0]          next_q;
    logic [PW-1:0]          new_q;
    logic [CW-1:0]          cnt_q;
    logic                   req_q;
    logic                   idle_q;
`ifdef SCHED_STATS_EN
    logic [DATA_WIDTH-1:0]  count_q;
`endif

    logic                   w_found_hi;
    logic                   w_found_lo;
    logic [PW-1:0]          w_sel_hi;
    logic [PW-1:0]          w_sel_lo;
    logic                   w_sel_found;
    logic [PW-1:0]          w_sel_pid;
    logic                   w_cur_ready;
    logic                   w_event;

    // Mask bit i holds PID i+1; clears are applied after sets so clear wins.
    always_comb begin
        mask_d = mask_q;
        for (int i = 0; i < NUM_PROCS; i++) begin
            if (set_valid && set_pid == PW'(i + 1)) mask_d[i] = 1'b1;
        end
        for (int i = 0; i < NUM_PROCS; i++) begin
            if (clr_valid && clr_pid == PW'(i + 1)) mask_d[i] = 1'b0;
        end
    end

    // Two-pass round-robin: lowest ready PID above cur_proc, else lowest at or below it.
    always_comb begin
        w_found_hi  = 1'b0;
        w_found_lo  = 1'b0;
        w_sel_hi    = '0;
        w_sel_lo    = '0;
        w_cur_ready = 1'b0;
        for (int i = NUM_PROCS - 1; i >= 0; i--) begin
            if (mask_q[i] && PW'(i + 1) > cur_q) begin
                w_found_hi = 1'b1;
                w_sel_hi   = PW'(i + 1);
            end
            if (mask_q[i] && PW'(i + 1) <= cur_q) begin
                w_found_lo = 1'b1;
                w_sel_lo   = PW'(i + 1);
            end
            if (PW'(i + 1) == cur_q) w_cur_ready = mask_q[i];
        end
        w_sel_found = w_found_hi | w_found_lo;
        w_sel_pid   = w_found_hi ? w_sel_hi : w_sel_lo;
        w_event     = (cnt_q == '0) || yield || !w_cur_ready;
    end

    always_ff @(posedge single_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            cur_q   <= '0;
            next_q  <= '0;
            new_q   <= '0;
            cnt_q   <= c_RELOAD;
            req_q   <= 1'b0;
            idle_q  <= 1'b1;
`ifdef SCHED_STATS_EN
            count_q <= '0;
`endif
        end else begin
            mask_q <= mask_d;
            new_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (enable && w_sel_found) begin
                        state_q <= S_REQ;
                        next_q  <= w_sel_pid;
                        req_q   <= 1'b1;
                        idle_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (enable) begin
                        if (w_event) begin
                            if (w_sel_found && w_sel_pid != cur_q) begin
                                state_q <= S_REQ;
                                next_q  <= w_sel_pid;
                                req_q   <= 1'b1;
                            end else if (w_sel_found) begin
                                cnt_q <= c_RELOAD;
                            end else begin
                                state_q <= S_REQ;
                                next_q  <= '0;
                                req_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (switch_ack) begin
                        state_q <= S_COMMIT;
                        req_q   <= 1'b0;
                    end
                end
                S_COMMIT: begin
                    cur_q   <= next_q;
                    new_q   <= next_q;
                    cnt_q   <= c_RELOAD;
                    state_q <= (next_q != '0) ? S_RUN : S_IDLE;
                    idle_q  <= (next_q == '0);
`ifdef SCHED_STATS_EN
                    if (next_q != '0) count_q <= count_q + 1'b1;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign switch_req   = req_q;
    assign idle         = idle_q;
    assign next_proc    = DATA_WIDTH'(next_q);
    assign cur_proc     = DATA_WIDTH'(cur_q);
    assign new_proc_num = DATA_WIDTH'(new_q);
`ifdef SCHED_STATS_EN
    assign switch_count = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_process_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_process_scheduler
// Description : Directed self-checking bench for process_scheduler
//               (NUM_PROCS=8, QUANTUM=16). Honours SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_process_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        set_valid;
    logic [3:0]  set_pid;
    logic        clr_valid;
    logic [3:0]  clr_pid;
    logic        yield;
    logic        switch_ack;
    logic        switch_req;
    logic        idle;
    logic [31:0] next_proc;
    logic [31:0] cur_proc;
    logic [31:0] new_proc_num;
`ifdef SCHED_STATS_EN
    logic [31:0] switch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    process_scheduler #(
        .DATA_WIDTH(32),
        .NUM_PROCS (8),
        .QUANTUM   (16)
    ) dut (
        .single_clk  (clk),
        .reset       (rst),
        .enable      (enable),
        .set_valid   (set_valid),
        .set_pid     (set_pid),
        .clr_valid   (clr_valid),
        .clr_pid     (clr_pid),
        .yield       (yield),
        .switch_req  (switch_req),
        .switch_ack  (switch_ack),
        .next_proc   (next_proc),
        .cur_proc    (cur_proc),
        .new_proc_num(new_proc_num),
        .idle        (idle)
`ifdef SCHED_STATS_EN
        ,
        .switch_count(switch_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one ack handshake and lands one cycle after the commit edge.
    task automatic ack_and_commit();
        switch_ack = 1'b1;
        tick();
        switch_ack = 1'b0;
        chk("req_drop_on_ack", {31'd0, switch_req}, 32'd0);
        chk("no_pulse_before_commit", new_proc_num, 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; set_valid = 1'b0; set_pid = 4'd0;
        clr_valid = 1'b0; clr_pid = 4'd0; yield = 1'b0; switch_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_req", {31'd0, switch_req}, 32'd0);
        chk("rst_cur", cur_proc, 32'd0);
        chk("rst_new", new_proc_num, 32'd0);
        chk("rst_next", next_proc, 32'd0);

        // Single PID 3 from idle
        enable = 1'b1; set_valid = 1'b1; set_pid = 4'd3;
        tick();
        set_valid = 1'b0;
        chk("t1_still_idle", {31'd0, idle}, 32'd1);
        tick();
        chk("t1_req", {31'd0, switch_req}, 32'd1);
        chk("t1_next", next_proc, 32'd3);
        chk("t1_idle_low", {31'd0, idle}, 32'd0);
        ack_and_commit();
        chk("t1_new", new_proc_num, 32'd3);
        chk("t1_cur", cur_proc, 32'd3);
        tick();
        chk("t1_new_pulse_end", new_proc_num, 32'd0);
        chk("t1_cur_hold", cur_proc, 32'd3);

        // Yield with PID 4 also ready
        set_valid = 1'b1; set_pid = 4'd4;
        tick();
        set_valid = 1'b0; yield = 1'b1;
        tick();
        yield = 1'b0;
        chk("t4_req", {31'd0, switch_req}, 32'd1);
        chk("t4_next", next_proc, 32'd4);

        // Reset mid-handshake
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_req", {31'd0, switch_req}, 32'd0);
        chk("t6_cur", cur_proc, 32'd0);
        chk("t6_idle", {31'd0, idle}, 32'd1);
        chk("t6_next", next_proc, 32'd0);
`ifdef SCHED_STATS_EN
        chk("t6_count", switch_count, 32'd0);
`endif
        tick(); tick();
        chk("t6_mask_empty", {31'd0, switch_req}, 32'd0);

        // PID 2 alone: quantum expiry reloads without a switch
        set_valid = 1'b1; set_pid = 4'd2;
        tick();
        set_valid = 1'b0;
        tick();
        chk("t3_next", next_proc, 32'd2);
        ack_and_commit();
        chk("t3_new", new_proc_num, 32'd2);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t3_no_req", {31'd0, switch_req}, 32'd0);
            chk("t3_no_pulse", new_proc_num, 32'd0);
        end
        chk("t3_cur", cur_proc, 32'd2);

        // Ready set {2,5,7}: yield from 2 picks 5
        set_valid = 1'b1; set_pid = 4'd5;
        tick();
        set_pid = 4'd7;
        tick();
        set_valid = 1'b0; yield = 1'b1;
        tick();
        yield = 1'b0;
        chk("t2_next5", next_proc, 32'd5);
        ack_and_commit();
        chk("t2_cur5", cur_proc, 32'd5);
        for (int i = 0; i < 15; i++) tick();
        chk("t2_no_req_at_15", {31'd0, switch_req}, 32'd0);
        tick();
        chk("t2_req_at_16", {31'd0, switch_req}, 32'd1);
        chk("t2_next7", next_proc, 32'd7);
        ack_and_commit();
        chk("t2_new7", new_proc_num, 32'd7);
        yield = 1'b1;
        tick();
        yield = 1'b0;
        chk("t2_wrap_next2", next_proc, 32'd2);
        ack_and_commit();
        chk("t2_cur2", cur_proc, 32'd2);

        // enable=0 drops the yield
        enable = 1'b0; yield = 1'b1;
        tick();
        enable = 1'b1; yield = 1'b0;
        chk("en0_no_req", {31'd0, switch_req}, 32'd0);

        // Clear all, then current PID: switch to idle
        clr_valid = 1'b1; clr_pid = 4'd5;
        tick();
        clr_pid = 4'd7;
        tick();
        clr_pid = 4'd2;
        tick();
        clr_valid = 1'b0;
        chk("t5_no_req_yet", {31'd0, switch_req}, 32'd0);
        tick();
        chk("t5_req", {31'd0, switch_req}, 32'd1);
        chk("t5_next0", next_proc, 32'd0);
        ack_and_commit();
        chk("t5_cur0", cur_proc, 32'd0);
        chk("t5_idle", {31'd0, idle}, 32'd1);
        chk("t5_new0", new_proc_num, 32'd0);

        // Same-cycle set/clr of 6 and out-of-range PID 9 leave mask empty
        set_valid = 1'b1; set_pid = 4'd6; clr_valid = 1'b1; clr_pid = 4'd6;
        tick();
        set_pid = 4'd9; clr_valid = 1'b0;
        tick();
        set_valid = 1'b0;
        tick(); tick();
        chk("clr_wins_idle", {31'd0, idle}, 32'd1);
        chk("clr_wins_no_req", {31'd0, switch_req}, 32'd0);

        // IDLE holds while disabled even with PID 1 ready
        enable = 1'b0; set_valid = 1'b1; set_pid = 4'd1;
        tick();
        set_valid = 1'b0;
        tick(); tick();
        chk("en0_idle_hold", {31'd0, switch_req}, 32'd0);
        enable = 1'b1;
        tick();
        chk("en1_req", {31'd0, switch_req}, 32'd1);
        chk("en1_next1", next_proc, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
